comb_lock_multi: RTL and testbench

Parametrised successor to the fixed 4-digit combination lock. It supports configurable digit width and code length, a valid-qualified digit handshake and a programmable code changed from the GRANT state. It also adds a configurable attempt limit and a timed lockout. The block sits between the keypad front-end (debounced enter_button, digit strobe) and the door-actuator / status-LED logic.

---
 rtl/comb_lock_pkg.sv | 21 ++
 rtl/comb_lock_multi_if.sv | 27 ++
 rtl/comb_lock_timer.sv | 25 ++
 rtl/comb_lock_multi.sv | 175 +++++++++++++++++
 tb/tb_comb_lock_multi.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/comb_lock_pkg.sv
// Shared types and defaults for the multi-digit combination lock.
//   state_t  : FSM state encoding
//   DEF_*    : default parameter values
//   width_of : bits needed to hold a value (minimum 1)
package comb_lock_pkg;

  typedef enum logic [2:0] {IDLE, CHECK, GRANT, DENY, LOCK, PROG} state_t;

  localparam int unsigned DEF_DIGIT_W       = 4;
  localparam int unsigned DEF_NUM_DIGITS    = 4;
  localparam logic [63:0] DEF_CODE          = 64'h1537;
  localparam int unsigned DEF_MAX_TRIES     = 3;
  localparam int unsigned DEF_TIMEOUT       = 100_000_000;
  localparam int unsigned DEF_GRANT_CYCLES  = 8;
  localparam int unsigned DEF_ENTRY_TIMEOUT = 50_000_000;

  function automatic int unsigned width_of(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/comb_lock_multi_if.sv
// Keypad / status bus of the combination lock.
//   master : keypad side (drives enter_button, digit_valid, ip_pass, prog_req)
//   slave  : lock side (drives grant, deny, lock, prog_active, fail_count)
interface comb_lock_multi_if #(
  parameter int unsigned DIGIT_W   = comb_lock_pkg::DEF_DIGIT_W,
  parameter int unsigned MAX_TRIES = comb_lock_pkg::DEF_MAX_TRIES
);
  logic                             enter_button;
  logic                             digit_valid;
  logic [DIGIT_W-1:0]               ip_pass;
  logic                             prog_req;
  logic                             grant;
  logic                             deny;
  logic                             lock;
  logic                             prog_active;
  logic [$clog2(MAX_TRIES+1)-1:0]   fail_count;

  modport master (
    output enter_button, digit_valid, ip_pass, prog_req,
    input  grant, deny, lock, prog_active, fail_count
  );

  modport slave (
    input  enter_button, digit_valid, ip_pass, prog_req,
    output grant, deny, lock, prog_active, fail_count
  );
endinterface

// File: rtl/comb_lock_timer.sv
// Loadable down-counter that stops at zero.
//   clk, rst : clock, synchronous active-high reset
//   load     : load load_val (priority over en)
//   en       : decrement while non-zero
//   expire   : count is zero
module comb_lock_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expire
);
  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)                       count <= '0;
    else if (load)                 count <= load_val;
    else if (en && count != '0)    count <= count - W'(1);
  end

  assign expire = (count == '0);
endmodule

// File: rtl/comb_lock_multi.sv
// Parametrised combination lock with attempt limit, timed lockout and
// code programming from GRANT.
//   clk, rst : clock, synchronous active-high reset
//   bus      : comb_lock_multi_if.slave (keypad inputs, status outputs)
// Optional: define COMB_LOCK_ENTRY_TIMEOUT_EN to add an inter-digit idle
// timeout (parameter ENTRY_TIMEOUT) in CHECK and PROG.
module comb_lock_multi import comb_lock_pkg::*; #(
  parameter int unsigned DIGIT_W       = DEF_DIGIT_W,
  parameter int unsigned NUM_DIGITS    = DEF_NUM_DIGITS,
  parameter logic [63:0] DEFAULT_CODE  = DEF_CODE,
  parameter int unsigned MAX_TRIES     = DEF_MAX_TRIES,
  parameter int unsigned TIMEOUT       = DEF_TIMEOUT,
  parameter int unsigned GRANT_CYCLES  = DEF_GRANT_CYCLES
`ifdef COMB_LOCK_ENTRY_TIMEOUT_EN
  , parameter int unsigned ENTRY_TIMEOUT = DEF_ENTRY_TIMEOUT
`endif
) (
  input logic               clk,
  input logic               rst,
  comb_lock_multi_if.slave  bus
);
  localparam int unsigned CODE_W   = DIGIT_W * NUM_DIGITS;
  localparam int unsigned IDX_W    = width_of(NUM_DIGITS - 1);
  localparam int unsigned FC_W     = $clog2(MAX_TRIES + 1);
  localparam int unsigned HOLD_MAX = (TIMEOUT > GRANT_CYCLES) ? TIMEOUT : GRANT_CYCLES;
  localparam int unsigned HT_W     = width_of(HOLD_MAX - 1);
  localparam logic [HT_W-1:0] LOCK_LOAD  = HT_W'(TIMEOUT - 1);
  localparam logic [HT_W-1:0] GRANT_LOAD = HT_W'(GRANT_CYCLES - 1);

  if (DIGIT_W < 1 || NUM_DIGITS < 1 || MAX_TRIES < 1 || TIMEOUT < 1 || GRANT_CYCLES < 1)
  begin : g_bad_param
    $error("comb_lock_multi: parameter out of range");
  end
  if (CODE_W > 64 || (CODE_W < 64 && (DEFAULT_CODE >> CODE_W) != 64'd0)) begin : g_bad_code
    $error("comb_lock_multi: DEFAULT_CODE wider than DIGIT_W*NUM_DIGITS");
  end

  state_t              state, nxt;
  logic [IDX_W-1:0]    idx;
  logic                mismatch;
  logic [CODE_W-1:0]   code, shadow, shadow_nxt;
  logic [FC_W-1:0]     fail_cnt;
  logic                grant_r, deny_r, lock_r, prog_r;
  logic [DIGIT_W-1:0]  digits [NUM_DIGITS];
  logic                last, mismatch_nxt;
  logic                ht_load, ht_en, ht_exp;
  logic [HT_W-1:0]     ht_val;
  logic                et_expire;

  always_comb begin
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      digits[i] = code[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W];
  end

  assign last         = (idx == IDX_W'(NUM_DIGITS - 1));
  assign mismatch_nxt = mismatch | (bus.ip_pass != digits[idx]);
  // Truncating the concatenation shifts the new digit in at the LS end.
  assign shadow_nxt   = CODE_W'({shadow, bus.ip_pass});

  // GRANT and LOCK never overlap, so one hold timer serves both.
  assign ht_en = (state == GRANT) || (state == LOCK);
  comb_lock_timer #(.W(HT_W)) u_hold (
    .clk(clk), .rst(rst), .load(ht_load), .en(ht_en), .load_val(ht_val), .expire(ht_exp)
  );

`ifdef COMB_LOCK_ENTRY_TIMEOUT_EN
  localparam int unsigned ET_W = width_of(ENTRY_TIMEOUT - 1);
  logic et_load, et_en, et_zero;
  if (ENTRY_TIMEOUT < 1) begin : g_bad_et
    $error("comb_lock_multi: ENTRY_TIMEOUT out of range");
  end
  assign et_load = (state == IDLE  && bus.enter_button) ||
                   (state == CHECK && (bus.enter_button || bus.digit_valid)) ||
                   (state == GRANT && bus.prog_req) ||
                   (state == PROG  && bus.digit_valid);
  assign et_en   = (state == CHECK) || (state == PROG);
  comb_lock_timer #(.W(ET_W)) u_entry (
    .clk(clk), .rst(rst), .load(et_load), .en(et_en),
    .load_val(ET_W'(ENTRY_TIMEOUT - 1)), .expire(et_zero)
  );
  assign et_expire = et_zero && et_en;
`else
  assign et_expire = 1'b0;
`endif

  always_comb begin
    nxt     = state;
    ht_load = 1'b0;
    ht_val  = GRANT_LOAD;
    unique case (state)
      IDLE:  if (bus.enter_button) nxt = CHECK;
      CHECK: begin
        if (bus.enter_button) nxt = CHECK;
        else if (bus.digit_valid) begin
          if (last) begin
            nxt     = mismatch_nxt ? DENY : GRANT;
            ht_load = !mismatch_nxt;
          end
        end else if (et_expire) nxt = DENY;
      end
      GRANT: begin
        if (bus.prog_req) nxt = PROG;
        else if (ht_exp)  nxt = IDLE;
      end
      DENY: begin
        if (fail_cnt == FC_W'(MAX_TRIES)) begin
          nxt     = LOCK;
          ht_load = 1'b1;
          ht_val  = LOCK_LOAD;
        end else nxt = IDLE;
      end
      LOCK:  if (ht_exp) nxt = IDLE;
      PROG: begin
        if (bus.digit_valid) begin
          if (last) nxt = IDLE;
        end else if (et_expire) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      mismatch <= 1'b0;
      code     <= CODE_W'(DEFAULT_CODE);
      shadow   <= '0;
      fail_cnt <= '0;
      grant_r  <= 1'b0;
      deny_r   <= 1'b0;
      lock_r   <= 1'b0;
      prog_r   <= 1'b0;
    end else begin
      state   <= nxt;
      grant_r <= (nxt == GRANT);
      deny_r  <= (nxt == DENY);
      lock_r  <= (nxt == LOCK);
      prog_r  <= (nxt == PROG);
      case (state)
        IDLE, GRANT: begin
          idx      <= '0;
          mismatch <= 1'b0;
        end
        CHECK: begin
          if (bus.enter_button) begin
            idx      <= '0;
            mismatch <= 1'b0;
          end else if (bus.digit_valid) begin
            idx      <= last ? '0 : idx + IDX_W'(1);
            mismatch <= mismatch_nxt;
          end
        end
        PROG: begin
          if (bus.digit_valid) begin
            shadow <= shadow_nxt;
            idx    <= last ? '0 : idx + IDX_W'(1);
            if (last) code <= shadow_nxt;
          end
        end
        default: ;
      endcase
      if (nxt == DENY && state != DENY)
        fail_cnt <= (fail_cnt == FC_W'(MAX_TRIES)) ? fail_cnt : fail_cnt + FC_W'(1);
      else if ((nxt == GRANT && state != GRANT) || (state == LOCK && nxt == IDLE))
        fail_cnt <= '0;
    end
  end

  assign bus.grant       = grant_r;
  assign bus.deny        = deny_r;
  assign bus.lock        = lock_r;
  assign bus.prog_active = prog_r;
  assign bus.fail_count  = fail_cnt;
endmodule

// File: tb/tb_comb_lock_multi.sv
// Scoreboard bench for comb_lock_multi: stimulus pushes expected status
// pulses (kind, fail_count, width, start cycle); a monitor pops and checks.
module tb_comb_lock_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   last_cyc = 0;

  typedef enum int {EV_NONE, EV_G, EV_D, EV_L, EV_P} ev_e;
  typedef struct {ev_e kind; int fc; int width; int at;} exp_t;
  exp_t sb[$];

  comb_lock_multi_if #(.DIGIT_W(4), .MAX_TRIES(3)) bus ();

  comb_lock_multi #(
    .DIGIT_W(4), .NUM_DIGITS(4), .DEFAULT_CODE(64'h1537),
    .MAX_TRIES(3), .TIMEOUT(20), .GRANT_CYCLES(4)
`ifdef COMB_LOCK_ENTRY_TIMEOUT_EN
    , .ENTRY_TIMEOUT(10)
`endif
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1);
  end

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  ev_e  prev_ev = EV_NONE;
  ev_e  ev;
  int   run = 0;
  exp_t cur;

  initial begin
    forever begin
      @(negedge clk);
      ev = (bus.grant === 1'b1) ? EV_G :
           (bus.deny === 1'b1)  ? EV_D :
           (bus.lock === 1'b1)  ? EV_L :
           (bus.prog_active === 1'b1) ? EV_P : EV_NONE;
      if (ev != prev_ev) begin
        if (prev_ev != EV_NONE && cur.width >= 0)
          check($sformatf("width_ev%0d", int'(prev_ev)), run, cur.width);
        if (ev != EV_NONE) begin
          if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_event: got ev%0d, expected none (cycle %0d)", int'(ev), cyc);
            cur = '{ev, 0, -1, -1};
          end else begin
            cur = sb.pop_front();
            check("event_kind", int'(ev), int'(cur.kind));
            check($sformatf("fail_count_ev%0d", int'(ev)), int'(bus.fail_count), cur.fc);
            check($sformatf("start_cycle_ev%0d", int'(ev)), cyc, cur.at);
          end
          run = 1;
        end
      end else if (ev != EV_NONE) run++;
      prev_ev = ev;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc_in(input bit en, input bit dv, input logic [3:0] d, input bit pr, input bit r);
    @(negedge clk);
    bus.enter_button = en;
    bus.digit_valid  = dv;
    bus.ip_pass      = d;
    bus.prog_req     = pr;
    rst              = r;
    last_cyc         = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc_in(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic push(input ev_e k, input int fc, input int w, input int at);
    exp_t e;
    e = '{k, fc, w, at};
    sb.push_back(e);
  endtask

  // gaps: 2 bits per inter-digit idle count, LS pair first
  task automatic send_code(input logic [15:0] c, input logic [5:0] gaps);
    cyc_in(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc_in(1'b0, 1'b1, c[15-4*i -: 4], 1'b0, 1'b0);
      if (i < 3) idle(int'(gaps[2*i +: 2]));
    end
  endtask

  task automatic try_grant(input logic [15:0] c, input logic [5:0] gaps);
    send_code(c, gaps);
    push(EV_G, 0, 4, last_cyc + 1);
    idle(6);
  endtask

  task automatic try_deny(input logic [15:0] c, input int fc);
    send_code(c, 6'd0);
    push(EV_D, fc, 1, last_cyc + 1);
    idle(3);
  endtask

  task automatic try_lock(input logic [15:0] c);
    send_code(c, 6'd0);
    push(EV_D, 3, 1, last_cyc + 1);
    push(EV_L, 3, 20, last_cyc + 2);
    for (int i = 0; i < 24; i++)
      cyc_in((i < 20) && (i % 5 == 3), 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  // abort_n = 0: program newc fully; otherwise reset after abort_n digits
  task automatic try_prog(input logic [15:0] c, input logic [15:0] newc, input int abort_n);
    int n;
    send_code(c, 6'd0);
    push(EV_G, 0, 1, last_cyc + 1);
    cyc_in(1'b0, 1'b0, 4'h0, 1'b1, 1'b0);
    n = (abort_n == 0) ? 4 : abort_n;
    push(EV_P, 0, (abort_n == 0) ? 4 : abort_n + 1, last_cyc + 1);
    for (int i = 0; i < n; i++)
      cyc_in(i == 1, 1'b1, newc[15-4*i -: 4], 1'b0, 1'b0);
    if (abort_n != 0) cyc_in(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    idle(3);
  endtask

  initial begin
    bus.enter_button = 1'b0;
    bus.digit_valid  = 1'b0;
    bus.ip_pass      = 4'h0;
    bus.prog_req     = 1'b0;
    repeat (3) cyc_in(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    idle(1);
    check("rst_grant", int'(bus.grant), 0);
    check("rst_deny", int'(bus.deny), 0);
    check("rst_lock", int'(bus.lock), 0);
    check("rst_prog", int'(bus.prog_active), 0);
    check("rst_fail_count", int'(bus.fail_count), 0);

    // 1: correct code, back-to-back digits
    try_grant(16'h1537, 6'b00_00_00);
    // 2: gapped correct code, then a wrong code
    try_grant(16'h1537, 6'b00_11_01);
    try_deny(16'h2000, 1);
    // 3: three consecutive failures lead to lockout
    try_grant(16'h1537, 6'd0);
    try_deny(16'h2000, 1);
    try_deny(16'h1597, 2);
    try_lock(16'h1530);
    check("fc_after_lock", int'(bus.fail_count), 0);
    try_grant(16'h1537, 6'd0);
    // 4: restart mid-entry does not count as an attempt
    try_deny(16'h2000, 1);
    cyc_in(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    cyc_in(1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
    cyc_in(1'b0, 1'b1, 4'h5, 1'b0, 1'b0);
    check("fc_mid_entry", int'(bus.fail_count), 1);
    try_grant(16'h1537, 6'd0);
    try_deny(16'h2000, 1);
    try_deny(16'h1597, 2);
    try_grant(16'h1537, 6'd0);
    // 5: programming a new code, then reset mid-programming
    try_prog(16'h1537, 16'h9246, 0);
    try_deny(16'h1537, 1);
    try_grant(16'h9246, 6'd0);
    try_prog(16'h9246, 16'h4444, 2);
    check("rst_mid_prog_fc", int'(bus.fail_count), 0);
    check("rst_mid_prog_active", int'(bus.prog_active), 0);
    try_grant(16'h1537, 6'd0);
`ifdef COMB_LOCK_ENTRY_TIMEOUT_EN
    // 6: inter-digit timeout during CHECK
    cyc_in(1'b1, 1'b0, 4'h0, 1'b0, 1'b0);
    cyc_in(1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
    cyc_in(1'b0, 1'b1, 4'h5, 1'b0, 1'b0);
    push(EV_D, 1, 1, last_cyc + 11);
    idle(14);
    check("fc_after_entry_timeout", int'(bus.fail_count), 1);
`endif
    idle(3);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
